// File: rtl/dev_uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM state encoding,
// header constant and byte selection from a flattened per-source data bus.
package dev_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_HOLD
    } state_t;

    localparam logic [7:0] HDR_BASE = 8'hA0;
    localparam int         MAX_N    = 8;

    // Callers zero-extend their 8*N bus to MAX_N bytes before selecting.
    function automatic logic [7:0] byte_sel(input logic [8*MAX_N-1:0] bus,
                                            input int unsigned         idx);
        return bus[8*idx +: 8];
    endfunction

endpackage

// File: rtl/dev_uart_tx_arb_if.sv
// Source-side and transmitter-side signals of the UART transmit arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface dev_uart_tx_arb_if #(
    parameter int N = 4
);
    logic [N-1:0]   req;
    logic [8*N-1:0] dat;
    logic [N-1:0]   last;
    logic [N-1:0]   ack;
    logic [N-1:0]   gnt;
    logic           tx_rdy;
    logic           tx_stb;
    logic [7:0]     tx_dat;
    logic           abort;

    modport master (
        input  req, dat, last, tx_rdy,
        output ack, gnt, tx_stb, tx_dat, abort
    );

    modport slave (
        output req, dat, last, tx_rdy,
        input  ack, gnt, tx_stb, tx_dat, abort
    );
endinterface

// File: rtl/dev_rr_pick.sv
// Combinational rotating-priority picker: returns the first requester found
// searching upward from ptr+1 with wrap-around, as a one-hot grant and an index.
module dev_rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] id
);

    int idx;

    // Walk from farthest to nearest so the nearest requester after ptr overwrites last.
    always_comb begin
        grant = '0;
        id    = '0;
        idx   = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                id         = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/dev_uart_tx_arb.sv
// Round-robin arbiter sharing one UART byte transmitter among N message sources,
// holding the grant for a whole message and optionally prefixing a channel header.
module dev_uart_tx_arb
    import dev_uart_pkg::*;
#(
    parameter int N      = 4,
    parameter bit HDR_EN = 1'b1
) (
    input logic                clk,
    input logic                rst_n,
    dev_uart_tx_arb_if.master  bus
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    state_t              state;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       gid;
    logic [PW-1:0]       pick_id;
    logic [N-1:0]        pick_grant;
    logic [N-1:0]        gnt_q;
    logic [N-1:0]        ack_q;
    logic                stb_q;
    logic [7:0]          dat_q;
    logic                abort_q;
    logic [8*MAX_N-1:0]  dat_pad;

    assign dat_pad = (8*MAX_N)'(bus.dat);

    dev_rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .grant (pick_grant),
        .id    (pick_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ptr     <= PW'(N - 1);
            gid     <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            stb_q   <= 1'b0;
            dat_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            ack_q   <= '0;
            stb_q   <= 1'b0;
            abort_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        gnt_q <= pick_grant;
                        gid   <= pick_id;
                        state <= HDR_EN ? ST_HDR : ST_DATA;
                    end
                end
                ST_HDR: begin
                    if (bus.tx_rdy) begin
                        stb_q <= 1'b1;
                        dat_q <= HDR_BASE | 8'(gid);
                        state <= ST_HOLD;
                    end
                end
                ST_DATA: begin
                    // A request drop wins over LAST: the message is abandoned unsent.
                    if (!bus.req[gid]) begin
                        abort_q <= 1'b1;
                        gnt_q   <= '0;
                        ptr     <= gid;
                        state   <= ST_IDLE;
                    end else if (bus.tx_rdy) begin
                        stb_q      <= 1'b1;
                        dat_q      <= byte_sel(dat_pad, int'(gid));
                        ack_q[gid] <= 1'b1;
                        if (bus.last[gid]) begin
                            gnt_q <= '0;
                            ptr   <= gid;
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // Transmitter ready may still be stale for one cycle after a strobe.
                    state <= ST_DATA;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.ack    = ack_q;
    assign bus.tx_stb = stb_q;
    assign bus.tx_dat = dat_q;
    assign bus.abort  = abort_q;

endmodule

// File: tb/tb_dev_uart_tx_arb.sv
// Directed self-checking bench for dev_uart_tx_arb with four sources, headers on,
// a byte-source model that advances on ACK and a transmitter model with a busy window.
module tb_dev_uart_tx_arb;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    dev_uart_tx_arb_if #(.N(4)) bus ();

    dev_uart_tx_arb #(
        .N      (4),
        .HDR_EN (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int tests    = 0;
    int failures = 0;

    logic [7:0] msg [4][4];
    int         len    [4];
    int         pos    [4];
    int         dropAt [4];
    bit         active [4];
    int         ackCnt [4];
    int         abortCnt;
    int         frameLen;
    int         busyCnt;
    logic [7:0] txLog  [$];
    logic [7:0] expLog [$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic driveSources();
        for (int i = 0; i < 4; i++) begin
            bus.req[i]         = active[i] && (pos[i] < len[i]) && (pos[i] != dropAt[i]);
            bus.dat[8*i +: 8]  = (pos[i] < len[i]) ? msg[i][pos[i]] : 8'h00;
            bus.last[i]        = (pos[i] == len[i] - 1);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 4; i++) begin
            active[i] = 1'b0;
            pos[i]    = 0;
            len[i]    = 0;
            dropAt[i] = -1;
            ackCnt[i] = 0;
        end
        abortCnt = 0;
        busyCnt  = 0;
        bus.tx_rdy = 1'b1;
        txLog.delete();
        driveSources();
    endtask

    task automatic resetCounts();
        for (int i = 0; i < 4; i++) ackCnt[i] = 0;
        abortCnt = 0;
        txLog.delete();
    endtask

    task automatic applyStimulus(input int src, input int n, input logic [31:0] bytes, input int drop);
        for (int k = 0; k < n; k++) msg[src][k] = bytes[8*k +: 8];
        len[src]    = n;
        pos[src]    = 0;
        dropAt[src] = drop;
        active[src] = 1'b1;
        driveSources();
    endtask

    // One clock: observe outputs just after the edge, then update source and transmitter models.
    task automatic tick();
        logic rdyBefore;
        rdyBefore = bus.tx_rdy;
        @(posedge clk);
        #1;
        if (bus.tx_stb) begin
            checkOutput("stbOnlyWhenReady", {31'd0, rdyBefore}, 32'd1);
            txLog.push_back(bus.tx_dat);
            if (frameLen > 0) busyCnt = frameLen;
        end else if (busyCnt > 0) begin
            busyCnt--;
        end
        bus.tx_rdy = (busyCnt == 0);
        if (bus.ack != 4'b0000) checkOutput("ackWithStb", {31'd0, bus.tx_stb}, 32'd1);
        if (bus.abort) begin
            abortCnt++;
            checkOutput("abortGntClear", {28'd0, bus.gnt}, 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            if (bus.ack[i]) begin
                ackCnt[i]++;
                pos[i]++;
            end
        end
        driveSources();
    endtask

    task automatic waitDone(input string tag, input int maxCycles);
        int n;
        n = 0;
        while (!(bus.req == 4'b0000 && bus.gnt == 4'b0000) && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput(tag, {31'd0, n < maxCycles}, 32'd1);
    endtask

    task automatic waitAck(input string tag, input int src, input int count, input int maxCycles);
        int n;
        n = 0;
        while (ackCnt[src] < count && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput(tag, {31'd0, ackCnt[src] >= count}, 32'd1);
    endtask

    task automatic checkLog(input string tag);
        checkOutput($sformatf("%s_len", tag), txLog.size(), expLog.size());
        for (int i = 0; i < expLog.size(); i++) begin
            if (i < txLog.size())
                checkOutput($sformatf("%s_byte%0d", tag, i), {24'd0, txLog[i]}, {24'd0, expLog[i]});
        end
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        clearModel();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        frameLen = 0;
        bus.req    = '0;
        bus.dat    = '0;
        bus.last   = '0;
        bus.tx_rdy = 1'b1;
        applyReset();

        // Reset state
        checkOutput("rst_gnt",   {28'd0, bus.gnt},    32'd0);
        checkOutput("rst_ack",   {28'd0, bus.ack},    32'd0);
        checkOutput("rst_stb",   {31'd0, bus.tx_stb}, 32'd0);
        checkOutput("rst_txdat", {24'd0, bus.tx_dat}, 32'd0);
        checkOutput("rst_abort", {31'd0, bus.abort},  32'd0);

        // Single source 2, three bytes, exact header latency and stable grant
        applyStimulus(2, 3, 32'h0033_2211, -1);
        tick();
        checkOutput("t1_gnt", {28'd0, bus.gnt}, 32'h4);
        checkOutput("t1_noStbYet", {31'd0, bus.tx_stb}, 32'd0);
        tick();
        checkOutput("t1_hdrStb", {31'd0, bus.tx_stb}, 32'd1);
        checkOutput("t1_hdrDat", {24'd0, bus.tx_dat}, 32'hA2);
        for (int c = 0; c < 20; c++) begin
            tick();
            if (ackCnt[2] < 3) begin
                checkOutput("t1_gntHeld", {28'd0, bus.gnt}, 32'h4);
            end else begin
                checkOutput("t1_gntDrop", {28'd0, bus.gnt}, 32'h0);
                break;
            end
        end
        expLog = {8'hA2, 8'h11, 8'h22, 8'h33};
        checkLog("t1_log");
        checkOutput("t1_acks", ackCnt[2], 32'd3);

        // All four request at once after reset: order 0,1,2,3
        applyReset();
        for (int i = 0; i < 4; i++) applyStimulus(i, 1, 32'h50 + i, -1);
        waitDone("t2_done", 60);
        expLog = {8'hA0, 8'h50, 8'hA1, 8'h51, 8'hA2, 8'h52, 8'hA3, 8'h53};
        checkLog("t2_log");
        for (int i = 0; i < 4; i++) checkOutput($sformatf("t2_ack%0d", i), ackCnt[i], 32'd1);

        // Source 1 mid-message while 0 and 3 arrive; rotation from 1 gives 3 then 0
        resetCounts();
        applyStimulus(1, 4, 32'h6463_6261, -1);
        waitAck("t3_twoAcks", 1, 2, 40);
        applyStimulus(0, 1, 32'h70, -1);
        applyStimulus(3, 1, 32'h73, -1);
        tick();
        checkOutput("t3_gntKept", {28'd0, bus.gnt}, 32'h2);
        waitDone("t3_done", 200);
        expLog = {8'hA1, 8'h61, 8'h62, 8'h63, 8'h64, 8'hA3, 8'h73, 8'hA0, 8'h70};
        checkLog("t3_log");

        // Source 3 drops its request after one byte; source 1 then proceeds
        resetCounts();
        applyStimulus(3, 3, 32'h0083_8281, 1);
        tick();
        tick();
        applyStimulus(1, 1, 32'h91, -1);
        tick();
        checkOutput("t4_gntKept", {28'd0, bus.gnt}, 32'h8);
        waitDone("t4_done", 100);
        expLog = {8'hA3, 8'h81, 8'hA1, 8'h91};
        checkLog("t4_log");
        checkOutput("t4_abortCnt", abortCnt, 32'd1);
        checkOutput("t4_ack3", ackCnt[3], 32'd1);
        checkOutput("t4_ack1", ackCnt[1], 32'd1);

        // Transmitter busy for 10 cycles after every strobe
        resetCounts();
        frameLen = 10;
        applyStimulus(0, 3, 32'h00B3_B2B1, -1);
        applyStimulus(2, 2, 32'h0000_C2C1, -1);
        waitDone("t5_done", 400);
        expLog = {8'hA2, 8'hC1, 8'hC2, 8'hA0, 8'hB1, 8'hB2, 8'hB3};
        checkLog("t5_log");
        checkOutput("t5_ack0", ackCnt[0], 32'd3);
        checkOutput("t5_ack2", ackCnt[2], 32'd2);
        frameLen = 0;
        for (int c = 0; c < 12; c++) tick();

        // Asynchronous reset mid-message, then a fresh start with source 0 first
        resetCounts();
        applyStimulus(1, 3, 32'h00E3_E2E1, -1);
        waitAck("t6_firstAck", 1, 1, 40);
        checkOutput("t6_gntBefore", {28'd0, bus.gnt}, 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rstGnt",   {28'd0, bus.gnt},    32'd0);
        checkOutput("t6_rstAck",   {28'd0, bus.ack},    32'd0);
        checkOutput("t6_rstStb",   {31'd0, bus.tx_stb}, 32'd0);
        checkOutput("t6_rstTxDat", {24'd0, bus.tx_dat}, 32'd0);
        checkOutput("t6_rstAbort", {31'd0, bus.abort},  32'd0);
        clearModel();
        tick();
        tick();
        rst_n = 1'b1;
        applyStimulus(3, 1, 32'hF3, -1);
        applyStimulus(0, 1, 32'hF0, -1);
        tick();
        checkOutput("t6_gntSrc0", {28'd0, bus.gnt}, 32'h1);
        waitDone("t6_done", 60);
        expLog = {8'hA0, 8'hF0, 8'hA3, 8'hF3};
        checkLog("t6_log");

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
